// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0, MSB-first SPI master transmitter with SCLK half-periods stretched to HALF_PERIOD clocks.
// Define SPI_MASTER_RX_EN to add the MISO capture path (miso_i / rx_data_o).
module spi_master_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 4
) (
  input  logic                  sysClk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
`ifdef SPI_MASTER_RX_EN
  input  logic                  miso_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  cs_n_o
);

  localparam int HW = $clog2(HALF_PERIOD);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int GW = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH);
  localparam logic [GW-1:0] GAP_LAST  = GW'((CS_GAP > 2) ? CS_GAP - 3 : 0);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         half_cnt_q, half_cnt_d, half_next;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d, bit_next;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, tx_shift;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  half_done;

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_d       = tx_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    half_done  = (half_cnt_q == HALF_LAST);
    half_next  = half_done ? half_cnt_q : half_cnt_q + 1'b1;
    bit_next   = (bit_cnt_q == BIT_LAST) ? bit_cnt_q : bit_cnt_q + 1'b1;
    tx_shift   = tx_q << 1;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = LEAD;
          tx_d       = data_i;
          mosi_d     = data_i[DATA_WIDTH-1];
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      LEAD: begin
        if (half_done) begin
          state_d    = HIGH;
          half_cnt_d = '0;
          sclk_d     = 1'b1;
          bit_cnt_d  = bit_next;
        end else begin
          half_cnt_d = half_next;
        end
      end
      HIGH: begin
        if (half_done) begin
          state_d    = LOW;
          half_cnt_d = '0;
          sclk_d     = 1'b0;
          if (bit_cnt_q != BIT_LAST) begin
            tx_d   = tx_shift;
            mosi_d = tx_shift[DATA_WIDTH-1];
          end
        end else begin
          half_cnt_d = half_next;
        end
      end
      LOW: begin
        // After the final falling edge CS is released on the very next cycle.
        if (bit_cnt_q == BIT_LAST) begin
          cs_n_d     = 1'b1;
          done_d     = 1'b1;
          mosi_d     = 1'b0;
          half_cnt_d = '0;
          if (CS_GAP == 1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = TRAIL;
          end
        end else if (half_done) begin
          state_d    = HIGH;
          half_cnt_d = '0;
          sclk_d     = 1'b1;
          bit_cnt_d  = bit_next;
        end else begin
          half_cnt_d = half_next;
        end
      end
      TRAIL: begin
        if (CS_GAP <= 2) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysClk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_q       <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_q       <= tx_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [DATA_WIDTH:0]   rx_cat;

  // MISO is sampled as SCLK rises; the assembled word is published when CS is released.
  always_comb begin
    rx_cat     = {rx_shift_q, miso_i};
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    if (state_d == HIGH && state_q != HIGH) rx_shift_d = rx_cat[DATA_WIDTH-1:0];
    if (done_d) rx_data_d = rx_shift_q;
  end

  always_ff @(posedge sysClk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_shift_q <= '0;
      rx_data_q  <= '0;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx_data_o = rx_data_q;
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign cs_n_o = cs_n_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Testbench for spi_master_tx: frame-level reference model plus directed frames and a synchronizing slave.
// Builds with or without SPI_MASTER_RX_EN.
module tb_spi_master_tx;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int G  = 4;
  localparam int W2 = 16;
  localparam int H2 = 2;
  localparam int G2 = 4;

  logic          sysClk = 1'b0;
  logic          slvClk = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          busy_o, done_o, sclk_o, mosi_o, cs_n_o;
  logic          start2 = 1'b0;
  logic [W2-1:0] data2 = '0;
  logic          busy2, done2, sclk2, mosi2, cs2;
  logic [W-1:0]  misoWord = '0;

  int checks = 0;
  int fails  = 0;

`ifdef SPI_MASTER_RX_EN
  logic          miso_i = 1'b0;
  logic [W-1:0]  rx_data_o;
  logic          miso2 = 1'b0;
  logic [W2-1:0] rx2;
`endif

  // Clocks with a 0.7 ratio: system period 14, slave period 20.
  always #7 sysClk = ~sysClk;
  always #10 slvClk = ~slvClk;

  spi_master_tx #(.DATA_WIDTH(W), .HALF_PERIOD(H), .CS_GAP(G)) dut (
    .sysClk_i(sysClk), .reset_i(reset_i), .start_i(start_i), .data_i(data_i),
`ifdef SPI_MASTER_RX_EN
    .miso_i(miso_i), .rx_data_o(rx_data_o),
`endif
    .busy_o(busy_o), .done_o(done_o), .sclk_o(sclk_o), .mosi_o(mosi_o), .cs_n_o(cs_n_o)
  );

  spi_master_tx #(.DATA_WIDTH(W2), .HALF_PERIOD(H2), .CS_GAP(G2)) dut2 (
    .sysClk_i(sysClk), .reset_i(reset_i), .start_i(start2), .data_i(data2),
`ifdef SPI_MASTER_RX_EN
    .miso_i(miso2), .rx_data_o(rx2),
`endif
    .busy_o(busy2), .done_o(done2), .sclk_o(sclk2), .mosi_o(mosi2), .cs_n_o(cs2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Frame model: outputs as a function of the cycle index c counted from the accept edge.
  int           cyc = 0;
  int           e0 = 0;
  bit           mActive = 0;
  logic [W-1:0] mWord = '0;
  logic [W-1:0] mRx = '0;
  logic [W-1:0] mRxNext = '0;
  logic         mCs = 1'b1, mSclk = 1'b0, mMosi = 1'b0, mBusy = 1'b0, mDone = 1'b0;
  bit           cmpEn = 0;

  task automatic computeExp(input int c);
    int k;
    mCs   = !(c <= 1 + 2*W*H);
    mSclk = (c < 1 + 2*W*H) && (((c - 1) / H) % 2 == 1);
    if (c <= 1 + 2*W*H) begin
      k = (c - 1) / (2*H);
      if (k > W - 1) k = W - 1;
      mMosi = mWord[W-1-k];
    end else begin
      mMosi = 1'b0;
    end
    mDone = (c == 2 + 2*W*H);
    mBusy = (c <= 2*W*H + G);
    if (mDone) mRx = mRxNext;
    if (!mBusy) mActive = 0;
  endtask

  always @(posedge sysClk or posedge reset_i) begin
    if (reset_i) begin
      mActive = 0;
      mCs = 1'b1; mSclk = 1'b0; mMosi = 1'b0; mBusy = 1'b0; mDone = 1'b0;
      mRx = '0;
    end else begin
      cyc++;
      if (!mActive && start_i) begin
        mActive = 1;
        e0 = cyc;
        mWord = data_i;
        mRxNext = misoWord;
      end
      if (mActive) computeExp(cyc - e0 + 1);
    end
  end

  always @(negedge sysClk) begin
    if (cmpEn) begin
      checkOutput("cs_n", cs_n_o, mCs);
      checkOutput("sclk", sclk_o, mSclk);
      checkOutput("mosi", mosi_o, mMosi);
      checkOutput("busy", busy_o, mBusy);
      checkOutput("done", done_o, mDone);
`ifdef SPI_MASTER_RX_EN
      checkOutput("rx_data", rx_data_o, mRx);
`endif
    end
  end

  // MOSI as seen by a mode-0 slave at each SCLK rise.
  int          riseCnt = 0;
  logic [31:0] riseWord = '0;
  logic        lastSclk = 1'b0;
  always @(negedge sysClk) begin
    if (sclk_o && !lastSclk) begin
      riseCnt++;
      riseWord = {riseWord[30:0], mosi_o};
    end
    lastSclk = sclk_o;
  end

`ifdef SPI_MASTER_RX_EN
  // Slave side of MISO: first bit with CS fall, next bit after each SCLK fall.
  int   fallIdx = 0;
  logic prevSclkM = 1'b0;
  always @(negedge sysClk) begin
    if (cs_n_o) fallIdx = 0;
    else if (prevSclkM && !sclk_o) fallIdx++;
    prevSclkM = sclk_o;
    miso_i = (fallIdx < W) ? misoWord[W-1-fallIdx] : 1'b0;
  end
`endif

  // Slave in its own clock domain: 2-FF synchronizers plus edge detection.
  logic [2:0]    sSclk = 3'b000, sMosi = 3'b000, sCs = 3'b111;
  logic [W2-1:0] slvWord = '0, slvGot = '0;
  int            slvBits = 0, slvGotBits = 0, slvFrames = 0;
  always @(posedge slvClk) begin
    sSclk <= {sSclk[1:0], sclk2};
    sMosi <= {sMosi[1:0], mosi2};
    sCs   <= {sCs[1:0], cs2};
    if (!sCs[1] && sCs[2]) slvBits <= 0;
    else if (sSclk[1] && !sSclk[2] && !sCs[1]) begin
      slvWord <= {slvWord[W2-2:0], sMosi[1]};
      slvBits <= slvBits + 1;
    end
    if (sCs[1] && !sCs[2]) begin
      slvGot     <= slvWord;
      slvGotBits <= slvBits;
      slvFrames  <= slvFrames + 1;
    end
  end

  task automatic applyStimulus(input logic s, input logic [W-1:0] d);
    @(negedge sysClk);
    #2;
    start_i = s;
    data_i  = d;
  endtask

  task automatic waitDone(input int c0, output int c);
    c = c0;
    while (!done_o && c < 400) begin
      @(negedge sysClk);
      c++;
    end
  endtask

  task automatic waitIdle(input int c0, output int c);
    c = c0;
    while (busy_o && c < 400) begin
      @(negedge sysClk);
      c++;
    end
  endtask

  initial begin
    int c;
    int hi;
    int f0;
    bit sawLow;

    repeat (2) @(negedge sysClk);
    checkOutput("reset_cs_n", cs_n_o, 1);
    checkOutput("reset_sclk", sclk_o, 0);
    checkOutput("reset_mosi", mosi_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_done", done_o, 0);
    #2;
    reset_i = 1'b0;
    cmpEn = 1;
    repeat (2) @(negedge sysClk);

    $display("[TB] frame A5 with default timing");
    misoWord = 8'h81;
    riseCnt = 0; riseWord = '0;
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b0, 8'h00);
    waitDone(1, c);
    checkOutput("a5_done_cycle", c, 66);
    checkOutput("a5_rise_bits", riseWord[7:0], 8'hA5);
    checkOutput("a5_rise_count", riseCnt, 8);
    waitIdle(c, c);
    checkOutput("a5_busy_low_cycle", c, 69);

`ifdef SPI_MASTER_RX_EN
    $display("[TB] receive 3C");
    misoWord = 8'h3C;
    applyStimulus(1'b1, 8'h5A);
    applyStimulus(1'b0, 8'h00);
    waitDone(1, c);
    checkOutput("rx_at_done", rx_data_o, 8'h3C);
    repeat (10) @(negedge sysClk);
    checkOutput("rx_hold", rx_data_o, 8'h3C);
    waitIdle(c, c);
`endif

    $display("[TB] back-to-back 01 then FF");
    riseCnt = 0; riseWord = '0;
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'hFF);
    waitDone(1, c);
    checkOutput("b2b_first_done_cycle", c, 66);
    checkOutput("b2b_first_bits", riseWord[7:0], 8'h01);
    hi = 0;
    while (cs_n_o && hi < 50) begin
      hi++;
      @(negedge sysClk);
    end
    checkOutput("b2b_cs_high_cycles", hi, G);
    riseCnt = 0; riseWord = '0;
    #2;
    start_i = 1'b0;
    waitDone(1, c);
    checkOutput("b2b_second_done_cycle", c, 66);
    checkOutput("b2b_second_bits", riseWord[7:0], 8'hFF);
    checkOutput("b2b_second_count", riseCnt, 8);
    waitIdle(c, c);

    $display("[TB] start pulse during a frame");
    riseCnt = 0; riseWord = '0;
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b0, 8'h00);
    repeat (20) @(negedge sysClk);
    applyStimulus(1'b1, 8'hC3);
    applyStimulus(1'b0, 8'h00);
    waitDone(23, c);
    checkOutput("ignore_done_cycle", c, 66);
    checkOutput("ignore_bits", riseWord[7:0], 8'h3C);
    waitIdle(c, c);
    sawLow = 0;
    repeat (30) begin
      @(negedge sysClk);
      if (!cs_n_o) sawLow = 1;
    end
    checkOutput("ignore_no_extra_frame", sawLow, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h96);
    applyStimulus(1'b0, 8'h00);
    repeat (29) @(negedge sysClk);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("midreset_cs_n", cs_n_o, 1);
    checkOutput("midreset_sclk", sclk_o, 0);
    checkOutput("midreset_mosi", mosi_o, 0);
    checkOutput("midreset_busy", busy_o, 0);
    checkOutput("midreset_done", done_o, 0);
`ifdef SPI_MASTER_RX_EN
    checkOutput("midreset_rx", rx_data_o, 0);
`endif
    @(negedge sysClk);
    #2;
    reset_i = 1'b0;
    riseCnt = 0; riseWord = '0;
    applyStimulus(1'b1, 8'h69);
    applyStimulus(1'b0, 8'h00);
    waitDone(1, c);
    checkOutput("after_reset_done_cycle", c, 66);
    checkOutput("after_reset_bits", riseWord[7:0], 8'h69);
    checkOutput("after_reset_count", riseCnt, 8);
    waitIdle(c, c);

    $display("[TB] synchronizing slave, W=16 H=2");
    f0 = slvFrames;
    @(negedge sysClk);
    #2;
    start2 = 1'b1;
    data2 = 16'hBEEF;
    @(negedge sysClk);
    #2;
    start2 = 1'b0;
    data2 = 16'h0000;
    c = 0;
    while (slvFrames == f0 && c < 500) begin
      @(negedge sysClk);
      c++;
    end
    checkOutput("slave_frame_seen", (slvFrames != f0), 1);
    checkOutput("slave_word", slvGot, 16'hBEEF);
    checkOutput("slave_bit_count", slvGotBits, 16);
    repeat (10) @(negedge sysClk);

    cmpEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
